// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input and instruction-RAM write bus of the instruction encoder
//
// Purpose: groups everything the instruction encoder exchanges with its program source
// and with the instruction RAM write port, so both sides connect through one port.
// Signals:
//   start, base_addr              session control from the source
//   in_valid, in_ready, in_last   field bundle handshake
//   f_opcode .. f_imm             instruction fields of the offered bundle
//   mem_addr, mem_wdata, mem_we   instruction RAM write port
//   busy, done, err               session status
//   err_cnt, word_cnt             per-session counters
// Modports: master = program source / bench side, slave = encoder side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [2:0]        f_opcode;
  logic [1:0]        f_op;
  logic [2:0]        f_rn;
  logic [2:0]        f_rd;
  logic [1:0]        f_shift;
  logic [2:0]        f_rm;
  logic [15:0]       f_imm;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        err_cnt;
  logic [ADDR_W:0]   word_cnt;

  modport master (
    output start, base_addr, in_valid, in_last,
    output f_opcode, f_op, f_rn, f_rd, f_shift, f_rm, f_imm,
    input  in_ready, mem_addr, mem_wdata, mem_we,
    input  busy, done, err, err_cnt, word_cnt
  );

  modport slave (
    input  start, base_addr, in_valid, in_last,
    input  f_opcode, f_op, f_rn, f_rd, f_shift, f_rm, f_imm,
    output in_ready, mem_addr, mem_wdata, mem_we,
    output busy, done, err, err_cnt, word_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs instruction field bundles into 16-bit words and writes them to instruction RAM
//
// Purpose: inverse of the datapath decoder. Each accepted field bundle is encoded into
// a 16-bit word and written to consecutive instruction RAM addresses starting at the
// session base address. Bundles whose immediate does not fit the selected format are
// rejected, counted and not written.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  instr_encoder_if slave modport (handshake, fields, RAM write port, status)
// Parameters:
//   ADDR_W     instruction memory address width
//   MAX_WORDS  maximum words written per session (1..2**ADDR_W)
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  localparam logic [ADDR_W:0] MAX_W = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [7:0]        ecnt_q, ecnt_d;
  logic              err_q, err_d;
  logic              last_q, last_d;

  logic              is_imm8;
  logic              is_imm5;
  logic [15:0]       enc_word;
  logic              imm_ok;
  logic              in_ready_c;

  // Format select and encoding, purely from the offered fields.
  assign is_imm8 = ((bus.f_opcode == 3'b110) && (bus.f_op == 2'b10)) || (bus.f_opcode == 3'b001);
  assign is_imm5 = (bus.f_opcode == 3'b011) || (bus.f_opcode == 3'b100);

  always_comb begin
    enc_word = {bus.f_opcode, bus.f_op, bus.f_rn, 8'h00};
    imm_ok   = 1'b1;
    if (is_imm8) begin
      enc_word[7:0] = bus.f_imm[7:0];
      // Fits in 8 signed bits when every bit from the sign position up is equal.
      imm_ok = (&bus.f_imm[15:7]) | ~(|bus.f_imm[15:7]);
    end else if (is_imm5) begin
      enc_word[7:0] = {bus.f_rd, bus.f_imm[4:0]};
      imm_ok = (&bus.f_imm[15:4]) | ~(|bus.f_imm[15:4]);
    end else begin
      // Register format: the immediate is not part of the word and never rejects.
      enc_word[7:0] = {bus.f_rd, bus.f_shift, bus.f_rm};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wcnt_d     = wcnt_q;
    ecnt_d     = ecnt_q;
    err_d      = 1'b0;
    last_d     = last_q;
    in_ready_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          wcnt_d  = '0;
          ecnt_d  = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (wcnt_q >= MAX_W) begin
          // Session full: nothing more is accepted, flag the overflow and close.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            if (imm_ok) begin
              wdata_d = enc_word;
              last_d  = bus.in_last;
              state_d = S_WRITE;
            end else begin
              err_d = 1'b1;
              if (ecnt_q != 8'hFF) begin
                ecnt_d = ecnt_q + 8'd1;
              end
              if (bus.in_last) begin
                state_d = S_DONE;
              end
            end
          end
        end
      end

      S_WRITE: begin
        // Address wraps naturally at 2**ADDR_W.
        addr_d  = addr_q + 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        state_d = last_q ? S_DONE : S_LOAD;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous reset
  // drops mem_we in the same instant.
  assign bus.in_ready  = in_ready_c;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err_cnt   = ecnt_q;
  assign bus.word_cnt  = wcnt_q;

endmodule
